// File: rtl/mnist_pool_binarize.sv
// Raster front-end for the MNIST gate network: thresholds 8-bit pixels, pools
// POOLxPOOL blocks by ink count and emits one binary image per frame over valid/ready.
module mnist_pool_binarize #(
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int POOL       = 4,
    parameter int PIX_THRESH = 128,
    parameter int CNT_THRESH = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       pix_valid,
    output logic                                       pix_ready,
    input  logic [7:0]                                 pix_data,
    input  logic                                       pix_last,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [(IMG_W/POOL)*(IMG_H/POOL)-1:0]       out_bits,
    output logic                                       err_frame
);
    localparam int NB    = IMG_W / POOL;
    localparam int NBH   = IMG_H / POOL;
    localparam int NBITS = NB * NBH;
    localparam int PW    = (POOL > 1) ? $clog2(POOL) : 1;
    localparam int BW    = ($clog2((NB > NBH) ? NB : NBH) > 0) ? $clog2((NB > NBH) ? NB : NBH) : 1;
    localparam int AW    = $clog2(POOL * POOL + 1);

    // Position is kept as (block, offset-within-block) pairs so no divider is needed.
    logic [PW-1:0]    sub_col_r;
    logic [BW-1:0]    blk_col_r;
    logic [PW-1:0]    sub_row_r;
    logic [BW-1:0]    band_r;
    logic [AW-1:0]    acc_r [NB];
    logic [NBITS-1:0] work_r;

    logic             col_end_s;
    logic             band_end_s;
    logic             frame_end_s;
    logic             xfer_s;
    logic             ink_s;
    logic             early_s;
    logic [AW-1:0]    sum_s [NB];
    logic [NB-1:0]    band_bits_s;
    logic [NBITS-1:0] merged_s;

    assign col_end_s   = (sub_col_r == PW'(POOL - 1)) && (blk_col_r == BW'(NB - 1));
    assign band_end_s  = col_end_s && (sub_row_r == PW'(POOL - 1));
    assign frame_end_s = band_end_s && (band_r == BW'(NBH - 1));
    assign pix_ready   = !(frame_end_s && out_valid && !out_ready);
    assign xfer_s      = pix_valid && pix_ready;
    assign ink_s       = ({1'b0, pix_data} >= 9'(PIX_THRESH));
    assign early_s     = xfer_s && pix_last && !frame_end_s;

    // Current pixel folded into its column counter, thresholded, and merged into the working image.
    always_comb begin
        merged_s = work_r;
        for (int j = 0; j < NB; j++) begin
            if (ink_s && (blk_col_r == BW'(j))) begin
                sum_s[j] = acc_r[j] + AW'(1);
            end else begin
                sum_s[j] = acc_r[j];
            end
            band_bits_s[j] = (sum_s[j] >= AW'(CNT_THRESH));
        end
        for (int b = 0; b < NBH; b++) begin
            if (band_end_s && (band_r == BW'(b))) begin
                merged_s[b*NB +: NB] = band_bits_s;
            end else begin
                merged_s[b*NB +: NB] = work_r[b*NB +: NB];
            end
        end
    end

    // Raster position, band accumulators and working image; an early pix_last discards the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_col_r <= PW'(0);
            blk_col_r <= BW'(0);
            sub_row_r <= PW'(0);
            band_r    <= BW'(0);
            work_r    <= NBITS'(0);
            for (int j = 0; j < NB; j++) acc_r[j] <= AW'(0);
        end else if (xfer_s) begin
            if (early_s) begin
                sub_col_r <= PW'(0);
                blk_col_r <= BW'(0);
                sub_row_r <= PW'(0);
                band_r    <= BW'(0);
                work_r    <= NBITS'(0);
                for (int j = 0; j < NB; j++) acc_r[j] <= AW'(0);
            end else begin
                if (sub_col_r == PW'(POOL - 1)) begin
                    sub_col_r <= PW'(0);
                    if (blk_col_r == BW'(NB - 1)) begin
                        blk_col_r <= BW'(0);
                        if (sub_row_r == PW'(POOL - 1)) begin
                            sub_row_r <= PW'(0);
                            if (band_r == BW'(NBH - 1)) begin
                                band_r <= BW'(0);
                            end else begin
                                band_r <= band_r + BW'(1);
                            end
                        end else begin
                            sub_row_r <= sub_row_r + PW'(1);
                        end
                    end else begin
                        blk_col_r <= blk_col_r + BW'(1);
                    end
                end else begin
                    sub_col_r <= sub_col_r + PW'(1);
                end
                for (int j = 0; j < NB; j++) begin
                    if (band_end_s) begin
                        acc_r[j] <= AW'(0);
                    end else begin
                        acc_r[j] <= sum_s[j];
                    end
                end
                if (frame_end_s) begin
                    work_r <= NBITS'(0);
                end else begin
                    work_r <= merged_s;
                end
            end
        end
    end

    // Output frame register and framing-error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_bits  <= NBITS'(0);
            err_frame <= 1'b0;
        end else begin
            err_frame <= xfer_s && (pix_last != frame_end_s);
            if (xfer_s && frame_end_s) begin
                out_valid <= 1'b1;
                out_bits  <= merged_s;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mnist_pool_binarize.sv
// Scoreboard bench for mnist_pool_binarize: a driver streams frames and queues the
// expected pooled image from a block-counting model; a negedge monitor checks outputs.
module tb_mnist_pool_binarize;
    localparam int W   = 28;
    localparam int NPX = 784;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [7:0]  pix_data = 8'h00;
    logic        pix_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [48:0] out_bits;
    logic        err_frame;

    int          total = 0;
    int          bad = 0;
    logic [48:0] q[$];
    logic        exp_err = 1'b0;
    logic [7:0]  img [NPX];

    always #5 clk = ~clk;

    mnist_pool_binarize dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_last(pix_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_bits(out_bits), .err_frame(err_frame)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // Reference: count ink pixels in each 4x4 block and compare with the count threshold.
    function automatic logic [48:0] model();
        logic [48:0] res = 49'h0;
        for (int br = 0; br < 7; br++)
            for (int bc = 0; bc < 7; bc++) begin
                int cnt = 0;
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++)
                        if (img[(br*4 + r)*W + bc*4 + c] >= 8'd128) cnt++;
                res[br*7 + bc] = (cnt >= 8);
            end
        return res;
    endfunction

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < NPX; i++) img[i] = v;
    endtask

    task automatic set_block(input int br, input int bc, input int n, input logic [7:0] v);
        for (int k = 0; k < n; k++) img[(br*4 + k/4)*W + bc*4 + k%4] = v;
    endtask

    task automatic fill_random();
        for (int br = 0; br < 7; br++)
            for (int bc = 0; bc < 7; bc++) begin
                int dens = $urandom_range(0, 16);
                for (int k = 0; k < 16; k++)
                    img[(br*4 + k/4)*W + bc*4 + k%4] = ($urandom_range(0, 15) < dens) ?
                        8'($urandom_range(128, 255)) : 8'($urandom_range(0, 127));
            end
    endtask

    task automatic idle(input int n, input bit rr);
        pix_valid = 1'b0;
        pix_last  = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (rr) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            exp_err = 1'b0;
        end
    endtask

    // Called just after a rising edge; returns just after the edge on which the pixel transferred.
    task automatic send_pixel(input logic [7:0] d, input logic l, input bit at_end, input bit rr);
        int waited = 0;
        logic exp_rdy;
        pix_valid = 1'b1;
        pix_data  = d;
        pix_last  = l;
        if (rr) out_ready = 1'($urandom_range(0, 1));
        forever begin
            #1;
            exp_rdy = !(at_end && (q.size() > 0) && !out_ready);
            check("pix_ready", 64'(pix_ready), 64'(exp_rdy));
            if (pix_ready) break;
            @(posedge clk); #1;
            exp_err = 1'b0;
            waited++;
            if (rr) out_ready = 1'($urandom_range(0, 1));
            else if (waited >= 3) out_ready = 1'b1;
            if (waited > 200) begin
                total++;
                bad++;
                $display("FAIL pix_ready_timeout actual=stalled required=accepted");
                finish_run();
            end
        end
        @(posedge clk); #1;
        exp_err = (l != at_end);
    endtask

    task automatic send_frame(input int n_px, input int last_at, input bit rr);
        logic [48:0] m = model();
        for (int p = 0; p < n_px; p++) begin
            send_pixel(img[p], (p == last_at), (p == NPX - 1), rr);
            if (p == NPX - 1) q.push_back(m);
        end
    endtask

    // Monitor: every output frame must match the scoreboard head, in order.
    always @(negedge clk) begin
        check("err_frame", 64'(err_frame), 64'(exp_err));
        check("out_valid", 64'(out_valid), 64'(q.size() > 0));
        if (out_valid && (q.size() > 0)) begin
            if (out_ready) begin
                check("out_bits", 64'(out_bits), 64'(q[0]));
                void'(q.pop_front());
            end else begin
                check("hold_bits", 64'(out_bits), 64'(q[0]));
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_bits", 64'(out_bits), 64'(0));
        check("rst_err", 64'(err_frame), 64'(0));
        check("rst_pix_ready", 64'(pix_ready), 64'(1));
        rst = 1'b0;

        fill(8'h00); send_frame(NPX, NPX - 1, 1'b0);
        fill(8'hFF); send_frame(NPX, NPX - 1, 1'b0);
        fill(8'h00); set_block(2, 3, 8, 8'h80); send_frame(NPX, NPX - 1, 1'b0);
        fill(8'h00); set_block(2, 3, 7, 8'h80); send_frame(NPX, NPX - 1, 1'b0);
        fill(8'h00); set_block(2, 3, 16, 8'h7F); send_frame(NPX, NPX - 1, 1'b0);
        idle(2, 1'b0);

        // Backpressure: frame 1 held, frame 2 stalls only on its final pixel.
        out_ready = 1'b0;
        fill_random(); send_frame(NPX, NPX - 1, 1'b0);
        fill_random(); send_frame(NPX, NPX - 1, 1'b0);
        idle(2, 1'b0);

        fill(8'hFF); send_frame(100, 99, 1'b0);
        idle(2, 1'b0);
        send_frame(NPX, NPX - 1, 1'b0);
        fill_random(); send_frame(NPX, -1, 1'b0);

        for (int f = 0; f < 6; f++) begin
            fill_random();
            send_frame(NPX, NPX - 1, 1'b1);
            idle($urandom_range(0, 2), 1'b1);
        end
        out_ready = 1'b1;
        idle(3, 1'b0);
        check("drained", 64'(q.size()), 64'(0));

        // Reset in the middle of a frame, then a clean all-ones frame.
        fill(8'hFF); send_frame(400, -1, 1'b0);
        pix_valid = 1'b0;
        rst = 1'b1;
        exp_err = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_out_bits", 64'(out_bits), 64'(0));
        check("midrst_pix_ready", 64'(pix_ready), 64'(1));
        repeat (2) @(posedge clk);
        #1;
        check("midrst_err", 64'(err_frame), 64'(0));
        rst = 1'b0;
        send_frame(NPX, NPX - 1, 1'b0);
        idle(3, 1'b0);
        check("final_bits", 64'(out_bits), 64'(49'h1_FFFF_FFFF_FFFF));
        check("final_drained", 64'(q.size()), 64'(0));
        finish_run();
    end
endmodule

// File: doc/mnist_pool_binarize.md
# mnist_pool_binarize

Upstream front-end for the 4-class MNIST gate network. It accepts a raster stream of 28x28 8-bit grayscale pixels and thresholds each pixel. It then pools non-overlapping 4x4 blocks into a 7x7 binary image and presents it as the 49-bit `in_bits` vector consumed by the classifier, using a valid/ready handshake. Output bit index = block_row*7 + block_col; block (0,0) is the top-left block.

## Interface
- `IMG_W`, 28: pixels per row; must equal 7*`POOL`.
- `IMG_H`, 28: rows per frame; must equal 7*`POOL`.
- `POOL`, 4: block edge in pixels.
- `PIX_THRESH`, 128: a pixel is ink when `pix_data >= PIX_THRESH`.
- `CNT_THRESH`, 8: a block bit is 1 when its ink count `>= CNT_THRESH`; legal range 1..`POOL*POOL`.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pix_valid`  in  1  pixel present.
- `pix_ready`  out  1  block accepts the pixel this cycle.
- `pix_data`  in  8  grayscale value.
- `pix_last`  in  1  marks the final pixel of a frame.
- `out_valid`  out  1  `out_bits` holds a completed frame.
- `out_ready`  in  1  downstream accepts the frame.
- `out_bits`  out  49  pooled binary image; feeds classifier `in_bits[48:0]`.
- `err_frame`  out  1  one-cycle pulse on a framing error.

## Operation
- A pixel transfer occurs when `pix_valid && pix_ready`.
- Position counters:
  - `col` (0..27) increments on each transfer.
  - At wrap, `col` returns to 0 and `row` (0..27) increments.
  - After (27,27), both counters return to 0.
- Band accumulators: seven 5-bit counters, one per block column (`col/POOL`). Each transfer adds 1 to counter `col/POOL` when the pixel is ink.
- Band close: on the transfer at `row%POOL==POOL-1 && col==IMG_W-1`:
  - All 7 counters are compared against `CNT_THRESH`.
  - Results are written to working bits [band*7 +: 7], where band = `row/POOL`.
  - All counters clear in the same cycle. The pixel being transferred is included in its counter before the compare.
- Frame close: on the transfer at (27,27):
  - The complete working vector, including band 6, is loaded into the `out_bits` register.
  - `out_valid` is set, and the working vector clears.
- Output handshake:
  - `out_valid` clears on `out_valid && out_ready`, unless a new frame loads in the same cycle, in which case it stays 1 with the new data.
  - `out_bits` holds its value until the next load.
- Backpressure: `pix_ready = !(row==27 && col==27 && out_valid && !out_ready)`. Only the final pixel of a frame can stall. All other pixels are accepted unconditionally at 1 pixel/cycle.
- Framing errors (`err_frame` pulses the cycle after the offending transfer):
  - `pix_last` at any position other than (27,27): the frame is discarded. Counters, working vector and position reset to 0. `out_valid`/`out_bits` are unaffected.
  - No `pix_last` at (27,27): the frame is still emitted normally; `err_frame` pulses.
- Reset (async, takes effect immediately):
  - `out_valid` = 0, `out_bits` = 0, `err_frame` = 0.
  - Position, accumulators and working vector = 0.
  - `pix_ready` = 1.
  - A frame in progress is lost. The first transfer after reset deasserts is pixel (0,0).

## Timing
- Latency: `out_valid` is 1 in the cycle after the final-pixel transfer.
- Back-to-back frames: the first pixel of frame N+1 may transfer in the cycle after the last pixel of frame N. No bubble is required.
- `pix_ready` depends combinationally on `out_ready`; there is no other combinational input-to-output path.
- Counter width: 5 bits, maximum 16, no overflow possible.
- `CNT_THRESH` compare is unsigned.

## Test plan
- All-zero frame (784 px of 0x00, `pix_last` on the 784th) -> `out_valid`=1 one cycle later, `out_bits`=49'h0, `err_frame`=0.
- All-0xFF frame -> `out_bits`=49'h1_FFFF_FFFF_FFFF.
- Threshold edge cases; each frame is otherwise 0x00:
  - 8 ink px (0x80) in block (2,3) -> only bit 17 set.
  - 7 ink px in block (2,3) -> 49'h0.
  - Pixels of 0x7F in block (2,3) -> not ink, bit 17 clear.
- Backpressure:
  - Hold `out_ready`=0 after frame 1 and stream frame 2 -> `pix_ready`=0 only at pixel (27,27) of frame 2; frame-1 `out_bits` stable.
  - Raise `out_ready` -> frame 2 loads in the same cycle, `out_valid` stays 1.
- Early `pix_last` at pixel 100 -> `err_frame` pulses once, no output.
  - A following clean all-0xFF frame -> all-ones output.
- Assert `rst` mid-frame at pixel 400, then stream a full all-0xFF frame:
  - During reset: `out_valid`=0, `out_bits`=0.
  - After the frame: all-ones output, `err_frame`=0.
